mem_arbiter: RTL and testbench

Shares the single external memory port between the instruction fetch requester (imem) and the data requester driven from decode (dmem). Each requester issues one-cycle request pulses. The arbiter buffers each request, then serializes them onto the memory port with one transaction outstanding. It routes each memory response back to the requester that issued it. It sits between the core's fetch/decode stages and the memory/bus interface.

---
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: buffers fetch and data request pulses and
// serializes them onto one memory port, one transaction in flight, dmem first.
module mem_arbiter (
    input  logic        rst,
    input  logic        clk,
    // request layout: {valid, instr, addr[31:0], wdata[31:0], wstrb[3:0]}
    input  logic [69:0] imem_in,
    output logic [32:0] imem_out,
    input  logic [69:0] dmem_in,
    output logic [32:0] dmem_out,
    output logic [69:0] memory_in,
    // response layout: {ready, rdata[31:0]}
    input  logic [32:0] memory_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_D = 2'b01,
        SERVE_I = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        dpend_valid_r;
    logic        dpend_valid_s;
    logic [67:0] dpend_r;
    logic [67:0] dpend_s;
    logic        ipend_valid_r;
    logic        ipend_valid_s;
    logic [67:0] ipend_r;
    logic [67:0] ipend_s;
    logic [69:0] req_r;
    logic [69:0] req_s;

    logic        d_cand_valid_s;
    logic [67:0] d_cand_s;
    logic        i_cand_valid_s;
    logic [67:0] i_cand_s;
    logic        sel_en_s;
    logic        mem_ready_s;

    assign mem_ready_s = memory_out[32];

    // Candidate gathering, buffer loading and request selection
    always_comb begin
        state_s       = state_r;
        req_s         = req_r;
        dpend_valid_s = dpend_valid_r;
        dpend_s       = dpend_r;
        ipend_valid_s = ipend_valid_r;
        ipend_s       = ipend_r;

        // A request arriving this cycle bypasses its buffer into selection.
        d_cand_valid_s = dmem_in[69] | dpend_valid_r;
        i_cand_valid_s = imem_in[69] | ipend_valid_r;
        if (dmem_in[69]) begin
            d_cand_s = dmem_in[67:0];
        end else begin
            d_cand_s = dpend_r;
        end
        if (imem_in[69]) begin
            i_cand_s = imem_in[67:0];
        end else begin
            i_cand_s = ipend_r;
        end

        if (dmem_in[69]) begin
            dpend_valid_s = 1'b1;
            dpend_s       = dmem_in[67:0];
        end else begin
            dpend_valid_s = dpend_valid_r;
        end
        if (imem_in[69]) begin
            ipend_valid_s = 1'b1;
            ipend_s       = imem_in[67:0];
        end else begin
            ipend_valid_s = ipend_valid_r;
        end

        // A ready seen in IDLE is spurious and falls through to plain selection.
        sel_en_s = (state_r == IDLE) | mem_ready_s;

        if (sel_en_s) begin
            if (d_cand_valid_s) begin
                state_s       = SERVE_D;
                req_s         = {1'b1, 1'b0, d_cand_s};
                dpend_valid_s = 1'b0;
            end else if (i_cand_valid_s) begin
                state_s       = SERVE_I;
                req_s         = {1'b1, 1'b1, i_cand_s[67:4], 4'b0000};
                ipend_valid_s = 1'b0;
            end else begin
                state_s = IDLE;
                req_s   = 70'd0;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State, pending buffers and the registered memory request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            dpend_valid_r <= 1'b0;
            dpend_r       <= 68'd0;
            ipend_valid_r <= 1'b0;
            ipend_r       <= 68'd0;
            req_r         <= 70'd0;
        end else begin
            state_r       <= state_s;
            dpend_valid_r <= dpend_valid_s;
            dpend_r       <= dpend_s;
            ipend_valid_r <= ipend_valid_s;
            ipend_r       <= ipend_s;
            req_r         <= req_s;
        end
    end

    assign memory_in = req_r;

    // Responses route back in the same cycle to whichever port owns the transaction.
    always_comb begin
        imem_out = {mem_ready_s & (state_r == SERVE_I), memory_out[31:0]};
        dmem_out = {mem_ready_s & (state_r == SERVE_D), memory_out[31:0]};
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based transaction model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [69:0] imem_in = 70'd0;
    logic [69:0] dmem_in = 70'd0;
    logic [69:0] memory_in;
    logic [32:0] imem_out;
    logic [32:0] dmem_out;
    logic [32:0] memory_out = 33'd0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .rst        (rst),
        .clk        (clk),
        .imem_in    (imem_in),
        .imem_out   (imem_out),
        .dmem_in    (dmem_in),
        .dmem_out   (dmem_out),
        .memory_in  (memory_in),
        .memory_out (memory_out)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int i_cnt  = 0;
    int d_cnt  = 0;

    // Model: per-port waiting queues, current owner (0 none, 1 dmem, 2 imem)
    logic [69:0] qd[$];
    logic [69:0] qi[$];
    int          owner = 0;
    logic [69:0] cur = 70'd0;

    function automatic logic [69:0] req(input logic instr, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] wstrb);
        return {1'b1, instr, addr, wdata, wstrb};
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qd.delete();
        qi.delete();
        owner = 0;
        cur   = 70'd0;
    endtask

    task automatic model_edge();
        if (dmem_in[69]) qd.push_back(dmem_in);
        if (imem_in[69]) qi.push_back(imem_in);
        if (owner == 0 || memory_out[32]) begin
            if (qd.size() > 0) begin
                cur = qd.pop_front();
                cur[68] = 1'b0;
                owner = 1;
            end else if (qi.size() > 0) begin
                cur = qi.pop_front();
                cur[68] = 1'b1;
                cur[3:0] = 4'h0;
                owner = 2;
            end else begin
                cur = 70'd0;
                owner = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        chk("memory_in", memory_in, cur);
    endtask

    task automatic check_route();
        #1;
        chk("imem_ready", 70'(imem_out[32]), 70'(memory_out[32] && owner == 2));
        chk("dmem_ready", 70'(dmem_out[32]), 70'(memory_out[32] && owner == 1));
        chk("rdata", 70'({imem_out[31:0], dmem_out[31:0]}),
            70'({memory_out[31:0], memory_out[31:0]}));
        i_cnt += int'(imem_out[32]);
        d_cnt += int'(dmem_out[32]);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  s;
        logic        ins;

        // Reset with a pending data request on the input
        #1;
        rst = 1'b0;
        model_reset();
        dmem_in = req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        #1;
        chk("reset_memory_in", memory_in, 70'd0);
        chk("reset_readies", 70'({imem_out[32], dmem_out[32]}), 70'd0);
        tick();
        tick();
        rst = 1'b1;
        dmem_in = 70'd0;
        repeat (3) begin
            check_route();
            tick();
        end
        chk("idle_after_reset", 70'(memory_in[69]), 70'd0);

        // Single fetch with three-cycle memory latency
        imem_in = req(1'b1, 32'h0000_0100, 32'h0, 4'h0);
        check_route();
        tick();
        imem_in = 70'd0;
        chk("fetch_valid_instr", 70'(memory_in[69:68]), 70'(2'b11));
        chk("fetch_addr", 70'(memory_in[67:36]), 70'(32'h0000_0100));
        check_route();
        tick();
        check_route();
        tick();
        chk("fetch_hold_addr", 70'(memory_in[67:36]), 70'(32'h0000_0100));
        memory_out = {1'b1, 32'h0000_0013};
        check_route();
        chk("fetch_resp", 70'(imem_out), 70'({1'b1, 32'h0000_0013}));
        chk("fetch_no_dready", 70'(dmem_out[32]), 70'd0);
        tick();
        memory_out = 33'd0;
        chk("fetch_done", 70'(memory_in[69]), 70'd0);

        // Collision: dmem store wins, fetch follows right after its response
        i_cnt = 0;
        d_cnt = 0;
        imem_in = req(1'b1, 32'h0000_0200, 32'h0, 4'h0);
        dmem_in = req(1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF);
        check_route();
        tick();
        imem_in = 70'd0;
        dmem_in = 70'd0;
        chk("coll_d_issue", memory_in, req(1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF));
        check_route();
        tick();
        memory_out = {1'b1, 32'h1234_5678};
        check_route();
        tick();
        memory_out = 33'd0;
        chk("coll_i_issue", memory_in, req(1'b1, 32'h0000_0200, 32'h0, 4'h0));
        check_route();
        tick();
        memory_out = {1'b1, 32'h0000_0093};
        check_route();
        tick();
        memory_out = 33'd0;
        check_route();
        chk("coll_counts", 70'({i_cnt[7:0], d_cnt[7:0]}), 70'(16'h0101));

        // Back-to-back zero-wait loads
        dmem_in = req(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        tick();
        dmem_in = 70'd0;
        memory_out = {1'b1, 32'hAAAA_0001};
        check_route();
        chk("b2b_ready1", 70'(dmem_out[32]), 70'd1);
        tick();
        memory_out = 33'd0;
        chk("b2b_gap", 70'(memory_in[69]), 70'd0);
        dmem_in = req(1'b0, 32'h0000_1004, 32'h0, 4'h0);
        check_route();
        tick();
        dmem_in = 70'd0;
        memory_out = {1'b1, 32'hAAAA_0002};
        check_route();
        chk("b2b_ready2", 70'(dmem_out[32]), 70'd1);
        tick();
        memory_out = 33'd0;

        // Reset mid-transaction drops the late response
        dmem_in = req(1'b0, 32'h0000_2000, 32'h0, 4'h0);
        check_route();
        tick();
        dmem_in = 70'd0;
        rst = 1'b0;
        model_reset();
        #1;
        chk("midreset_clear", memory_in, 70'd0);
        tick();
        rst = 1'b1;
        memory_out = {1'b1, 32'h5555_5555};
        check_route();
        chk("midreset_no_ready", 70'({imem_out[32], dmem_out[32]}), 70'd0);
        tick();
        memory_out = 33'd0;
        chk("midreset_idle", 70'(memory_in[69]), 70'd0);

        // Spurious ready while idle, then a normal fetch
        memory_out = {1'b1, 32'h7777_7777};
        check_route();
        chk("spurious_readies", 70'({imem_out[32], dmem_out[32]}), 70'd0);
        tick();
        memory_out = 33'd0;
        imem_in = req(1'b1, 32'h0000_0300, 32'h0, 4'h0);
        check_route();
        tick();
        imem_in = 70'd0;
        chk("spurious_then_fetch", memory_in, req(1'b1, 32'h0000_0300, 32'h0, 4'h0));
        memory_out = {1'b1, 32'h0};
        check_route();
        tick();
        memory_out = 33'd0;

        // Randomized traffic obeying the one-outstanding-per-requester rule
        for (int n = 0; n < 600; n++) begin
            if (cur[69])
                memory_out = {($urandom_range(0, 2) == 0), $urandom};
            else
                memory_out = {($urandom_range(0, 15) == 0), $urandom};
            dmem_in = 70'd0;
            imem_in = 70'd0;
            if (!(qd.size() > 0 || owner == 1) && $urandom_range(0, 2) == 0) begin
                a = $urandom; w = $urandom; s = 4'($urandom_range(0, 15));
                ins = 1'($urandom_range(0, 1));
                dmem_in = req(ins, a, w, s);
            end
            if (!(qi.size() > 0 || owner == 2) && $urandom_range(0, 2) == 0) begin
                a = $urandom; w = $urandom; s = 4'($urandom_range(0, 15));
                ins = 1'($urandom_range(0, 1));
                imem_in = req(ins, a, w, s);
            end
            check_route();
            tick();
        end
        dmem_in = 70'd0;
        imem_in = 70'd0;
        memory_out = 33'd0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
